blink_detector: RTL and testbench

//  Receive side of the blink output: measures the half-period of an external toggling

---
 rtl/blinky_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/blink_detector.sv | 147 ++++++++++++++
 tb/tb_blink_detector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// Shared definitions for the blink generator / detector family.
//   CNT_DW      default width of half-period counters
//   LOCK_N_DEF  default number of consecutive matching measurements for lock
//   TOL_DEF     default half-period match tolerance in cycles
//   det_state_e detector FSM states
package blinky_pkg;

  localparam int unsigned CNT_DW     = 8;
  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned TOL_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } det_state_e;

endpackage : blinky_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk_i   destination clock
//   rst_ni  asynchronous reset, active-low (both flops clear to 0)
//   d_i     asynchronous input
//   q_o     synchronised output, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true two-stage shift; blocking
      // ones would collapse both stages into a single flop.
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule : sync_2ff

// File: rtl/blink_detector.sv
// Measures the half-period of an external toggling input, declares lock once
// LOCK_N consecutive measurements agree within TOL cycles, and flags loss of
// signal when the counter saturates without seeing a toggle.
//   clk_i           clock
//   rst_ni          asynchronous reset, active-low
//   en_i            measurement enable; low returns the detector to IDLE
//   blink_i         toggling input, asynchronous to clk_i
//   period_o        last measured half-period in cycles, held between updates
//   period_valid_o  1-cycle pulse, period_o updated in the same cycle
//   locked_o        level, half-period stable
//   timeout_o       1-cycle pulse, no toggle for 2**DW-1 cycles
module blink_detector
  import blinky_pkg::*;
#(
  parameter int unsigned DW     = CNT_DW,
  parameter int unsigned LOCK_N = LOCK_N_DEF,
  parameter int unsigned TOL    = TOL_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          blink_i,
  output logic [DW-1:0] period_o,
  output logic          period_valid_o,
  output logic          locked_o,
  output logic          timeout_o
);

  localparam int unsigned MW = $clog2(LOCK_N + 1);

  // Edge detection on the synchronised input
  logic blink_s, blink_d;
  logic blink_edge;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (blink_i),
    .q_o    (blink_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) blink_d <= 1'b0;
    else         blink_d <= blink_s;
  end

  assign blink_edge = blink_s ^ blink_d;

  // Detector state
  det_state_e      state_q;
  logic [DW-1:0]   cnt_q;
  logic [MW-1:0]   match_q;
  logic            have_prev_q;

  // Comparator: absolute difference is formed one bit wider so the subtraction
  // never wraps, then compared against the tolerance.
  logic [DW:0]   cnt_ext, prev_ext, diff;
  logic          within_tol;
  logic [MW-1:0] match_inc;
  logic          cnt_max;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_ext    = {1'b0, cnt_q};
    prev_ext   = {1'b0, period_o};
    diff       = '0;
    if (cnt_ext >= prev_ext) diff = cnt_ext - prev_ext;
    else                     diff = prev_ext - cnt_ext;
    within_tol = (diff <= (DW+1)'(TOL));
    match_inc  = (match_q == MW'(LOCK_N)) ? match_q : match_q + 1'b1;
    cnt_max    = (cnt_q == '1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every register, outputs included, returns to a defined value on
    // reset so no pulse or stale lock can appear after release.
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_q        <= '0;
      have_prev_q    <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      period_valid_o <= 1'b0;
      timeout_o      <= 1'b0;

      if (!en_i) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        match_q     <= '0;
        have_prev_q <= 1'b0;
        locked_o    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (blink_edge) begin
              state_q     <= ACQ;
              cnt_q       <= DW'(1);
              have_prev_q <= 1'b0;
            end
          end

          ACQ, LOCK: begin
            // An edge in the saturation cycle is still a valid measurement,
            // so it takes priority over the timeout.
            if (blink_edge) begin
              period_o       <= cnt_q;
              period_valid_o <= 1'b1;
              cnt_q          <= DW'(1);
              if (!have_prev_q) begin
                have_prev_q <= 1'b1;
                match_q     <= '0;
              end else if (within_tol) begin
                match_q <= match_inc;
                if (match_inc == MW'(LOCK_N)) begin
                  state_q  <= LOCK;
                  locked_o <= 1'b1;
                end
              end else begin
                match_q  <= '0;
                state_q  <= ACQ;
                locked_o <= 1'b0;
              end
            end else if (cnt_max) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              match_q     <= '0;
              have_prev_q <= 1'b0;
              locked_o    <= 1'b0;
              timeout_o   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule : blink_detector

// File: tb/tb_blink_detector.sv
// Scoreboard bench: stimulus pushes the expected (period, locked) pair for each
// toggle that completes a measurement; per-DUT monitors pop and compare on
// every period_valid_o pulse. Two instances: DW=8 and DW=6.
module tb_blink_detector;

  typedef struct packed {
    logic [7:0] period;
    logic       locked;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en8, en6, blink8, blink6;

  logic [7:0] period8;
  logic [5:0] period6;
  logic valid8, locked8, timeout8;
  logic valid6, locked6, timeout6;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_valid_cyc6 = 0;
  int tcnt8 = 0;
  int tcnt6 = 0;

  exp_t q8[$];
  exp_t q6[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blink_detector #(.DW(8), .LOCK_N(4), .TOL(2)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .blink_i(blink8),
    .period_o(period8), .period_valid_o(valid8), .locked_o(locked8), .timeout_o(timeout8)
  );

  blink_detector #(.DW(6), .LOCK_N(4), .TOL(2)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en6), .blink_i(blink6),
    .period_o(period6), .period_valid_o(valid6), .locked_o(locked6), .timeout_o(timeout6)
  );

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (valid8) begin
      if (q8.size() == 0) check("dut8_unexpected_valid", 1, 0);
      else begin
        e = q8.pop_front();
        check("dut8_period", int'(period8), int'(e.period));
        check("dut8_locked", int'(locked8), int'(e.locked));
      end
    end
    if (timeout8) tcnt8++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid6) begin
      last_valid_cyc6 = cyc;
      if (q6.size() == 0) check("dut6_unexpected_valid", 1, 0);
      else begin
        e = q6.pop_front();
        check("dut6_period", int'(period6), int'(e.period));
        check("dut6_locked", int'(locked6), int'(e.locked));
      end
    end
    if (timeout6) tcnt6++;
  end

  task automatic exp8(input int p, input bit l);
    exp_t e;
    e.period = 8'(p);
    e.locked = l;
    q8.push_back(e);
  endtask

  task automatic exp6(input int p, input bit l);
    exp_t e;
    e.period = 8'(p);
    e.locked = l;
    q6.push_back(e);
  endtask

  // Toggle after n cycles: edge spacing equals n, so the measured period is n.
  task automatic tog8(input int n);
    repeat (n) @(negedge clk);
    blink8 = ~blink8;
  endtask

  task automatic tog6(input int n);
    repeat (n) @(negedge clk);
    blink6 = ~blink6;
  endtask

  // Wait for a dut6 timeout pulse; returns cycles since last valid, -1 if none.
  task automatic wait_timeout6(input int budget, output int delta);
    delta = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (timeout6) begin
        delta = cyc - last_valid_cyc6;
        break;
      end
    end
  endtask

  int jit[5] = '{15, 17, 16, 18, 16};

  initial begin
    int delta;
    int tc_before;
    rst_n = 1'b0; en8 = 1'b1; en6 = 1'b1; blink8 = 1'b0; blink6 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(period8), 0);
    check("rst_valid", int'(valid8), 0);
    check("rst_locked", int'(locked8), 0);
    check("rst_timeout", int'(timeout8), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: steady 16, lock on 6th edge
    tog8(4);
    for (int i = 0; i < 5; i++) begin exp8(16, i == 4); tog8(16); end
    // 2: one half-period of 20 drops lock, four more relock
    exp8(20, 0); tog8(20);
    for (int i = 0; i < 4; i++) begin exp8(20, i == 3); tog8(20); end
    // 3: back to 16 and lock, jitter within TOL holds, 19 after 16 drops
    exp8(16, 0); tog8(16);
    for (int i = 0; i < 4; i++) begin exp8(16, i == 3); tog8(16); end
    for (int i = 0; i < 5; i++) begin exp8(jit[i], 1); tog8(jit[i]); end
    exp8(19, 0); tog8(19);
    // relock at 16 for the enable test
    exp8(16, 0); tog8(16);
    for (int i = 0; i < 4; i++) begin exp8(16, i == 3); tog8(16); end
    repeat (8) @(negedge clk);
    check("t6_locked_before_en", int'(locked8), 1);
    check("t6_queue_drained", q8.size(), 0);
    // 6: enable low for one cycle while locked
    en8 = 1'b0;
    @(negedge clk);
    check("t6_locked_after_en", int'(locked8), 0);
    check("t6_period_held", int'(period8), 16);
    en8 = 1'b1;

    // 4: DW=6, lock at 16 then stop toggling
    tog6(3);
    for (int i = 0; i < 5; i++) begin exp6(16, i == 4); tog6(16); end
    wait_timeout6(150, delta);
    check("t4_timeout_delay", delta, 63);
    check("t4_locked_cleared", int'(locked6), 0);
    check("t4_period_held", int'(period6), 16);
    @(negedge clk);
    check("t4_timeout_pulse_1cyc", int'(timeout6), 0);
    check("t4_timeout_count", tcnt6, 1);

    // 5: edge in the cycle cnt==MAX wins over timeout
    tog6(5);
    tc_before = tcnt6;
    exp6(63, 0); tog6(63);
    repeat (10) @(negedge clk);
    check("t5_no_timeout", tcnt6 - tc_before, 0);
    check("t5_period_max", int'(period6), 63);
    wait_timeout6(100, delta);
    check("t5_later_timeout", delta, 63);

    // 6b: async reset mid-count
    tog8(16);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_period8", int'(period8), 0);
    check("rst_mid_locked8", int'(locked8), 0);
    check("rst_mid_valid8", int'(valid8), 0);
    check("rst_mid_period6", int'(period6), 0);
    blink8 = 1'b0; blink6 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("end_q8_empty", q8.size(), 0);
    check("end_q6_empty", q6.size(), 0);
    check("dut8_no_timeouts", tcnt8, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_blink_detector
